// File: rtl/score_bcd_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | score_bcd_counter: saturating 4-digit BCD score, one digit added per cycle |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module score_bcd_counter #(
  parameter logic [3:0] PTS_1 = 4'd1,
  parameter logic [3:0] PTS_2 = 4'd3,
  parameter logic [3:0] PTS_3 = 4'd5,
  parameter logic [3:0] PTS_4 = 4'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       clr_valid,
  input  logic [2:0] clr_lines,
  output logic       clr_ready,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic [3:0] score4,
  output logic       score_upd,
  output logic       saturated
);

  // ADDk encodings equal k so the low bits select the digit being summed
  typedef enum logic [2:0] {
    ADD0   = 3'd0,
    ADD1   = 3'd1,
    ADD2   = 3'd2,
    ADD3   = 3'd3,
    COMMIT = 3'd4,
    IDLE   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      addend_q, addend_d;
  logic            carry_q, carry_d;
  logic            sat_q, sat_d;
  logic [3:0][3:0] work_q, work_d;
  logic [3:0][3:0] score_q, score_d;
  logic            saturated_q, saturated_d;
  logic            score_upd_q, score_upd_d;
  logic            clr_ready_q, clr_ready_d;

  logic [1:0]      digit_idx;
  logic [4:0]      raw_sum;

  always_comb begin
    state_d     = state_q;
    addend_d    = addend_q;
    carry_d     = carry_q;
    sat_d       = sat_q;
    work_d      = work_q;
    score_d     = score_q;
    saturated_d = saturated_q;
    score_upd_d = 1'b0;

    digit_idx = state_q[1:0];
    raw_sum   = {1'b0, work_q[digit_idx]}
              + {1'b0, (state_q == ADD0) ? addend_q : 4'd0}
              + {4'd0, carry_q};

    if (new_game) begin
      state_d     = IDLE;
      work_d      = '0;
      score_d     = '0;
      saturated_d = 1'b0;
      carry_d     = 1'b0;
      sat_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_valid) begin
            case (clr_lines)
              3'd1:    addend_d = PTS_1;
              3'd2:    addend_d = PTS_2;
              3'd3:    addend_d = PTS_3;
              3'd4:    addend_d = PTS_4;
              default: addend_d = 4'd0;
            endcase
            carry_d = 1'b0;
            sat_d   = 1'b0;
            state_d = ADD0;
          end
        end
        ADD0, ADD1, ADD2, ADD3: begin
          // Low nibble minus ten wraps mod 16 to the correct BCD digit
          if (raw_sum > 5'd9) begin
            work_d[digit_idx] = raw_sum[3:0] - 4'd10;
            carry_d           = 1'b1;
          end else begin
            work_d[digit_idx] = raw_sum[3:0];
            carry_d           = 1'b0;
          end
          if (state_q == ADD3) begin
            sat_d   = (raw_sum > 5'd9);
            state_d = COMMIT;
          end else begin
            state_d = state_t'(state_q + 3'd1);
          end
        end
        COMMIT: begin
          score_upd_d = 1'b1;
          if (sat_q) begin
            work_d      = {4{4'd9}};
            score_d     = {4{4'd9}};
            saturated_d = 1'b1;
          end else begin
            score_d = work_q;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    clr_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addend_q    <= '0;
      carry_q     <= 1'b0;
      sat_q       <= 1'b0;
      work_q      <= '0;
      score_q     <= '0;
      saturated_q <= 1'b0;
      score_upd_q <= 1'b0;
      clr_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addend_q    <= addend_d;
      carry_q     <= carry_d;
      sat_q       <= sat_d;
      work_q      <= work_d;
      score_q     <= score_d;
      saturated_q <= saturated_d;
      score_upd_q <= score_upd_d;
      clr_ready_q <= clr_ready_d;
    end
  end

  assign clr_ready = clr_ready_q;
  assign score1    = score_q[0];
  assign score2    = score_q[1];
  assign score3    = score_q[2];
  assign score4    = score_q[3];
  assign score_upd = score_upd_q;
  assign saturated = saturated_q;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_counter.sv
`default_nettype none
// Scoreboard bench for score_bcd_counter: integer score model, queue of expected commits.
module tb_score_bcd_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       clr_valid = 1'b0;
  logic [2:0] clr_lines = 3'd0;
  logic       clr_ready;
  logic [3:0] score1, score2, score3, score4;
  logic       score_upd;
  logic       saturated;

  score_bcd_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .new_game  (new_game),
    .clr_valid (clr_valid),
    .clr_lines (clr_lines),
    .clr_ready (clr_ready),
    .score1    (score1),
    .score2    (score2),
    .score3    (score3),
    .score4    (score4),
    .score_upd (score_upd),
    .saturated (saturated)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] digits;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_score = 0;
  bit   model_sat = 1'b0;

  function automatic int pts_for(input int lines);
    case (lines)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one accepted event: saturate when the sum would exceed 9999
  task automatic model_accept(input int lines);
    exp_t e;
    if (model_score + pts_for(lines) > 9999) begin
      model_score = 9999;
      model_sat   = 1'b1;
    end else begin
      model_score = model_score + pts_for(lines);
    end
    e.digits = to_bcd(model_score);
    e.sat    = model_sat;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_score = 0;
    model_sat   = 1'b0;
  endtask

  // Monitor: every committed score must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n && score_upd) begin
      if (exp_q.size() == 0) begin
        check("unexpected_score_upd", 32'(score_upd), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("score_digits", 32'({score4, score3, score2, score1}), 32'(e.digits));
        check("saturated", 32'(saturated), 32'(e.sat));
      end
    end
  end

  task automatic wait_ready();
    int waited = 0;
    while (!clr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!clr_ready) check("ready_timeout", 32'(clr_ready), 32'd1);
  endtask

  task automatic send(input int lines);
    @(negedge clk);
    wait_ready();
    clr_valid = 1'b1;
    clr_lines = 3'(lines);
    @(posedge clk);
    model_accept(lines);
    @(negedge clk);
    clr_valid = 1'b0;
    clr_lines = 3'($urandom_range(0, 7));
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int accepts;

    // Reset values while held in reset
    idle_cycles(3);
    check("rst_ready", 32'(clr_ready), 32'd1);
    check("rst_digits", 32'({score4, score3, score2, score1}), 32'd0);
    check("rst_upd", 32'(score_upd), 32'd0);
    check("rst_sat", 32'(saturated), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Single event: ready low for five cycles, commit visible after the fifth edge
    wait_ready();
    clr_valid = 1'b1;
    clr_lines = 3'd1;
    @(posedge clk);
    model_accept(1);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      clr_valid = 1'b0;
      if (k < 5) begin
        check("lat_ready_low", 32'(clr_ready), 32'd0);
        check("lat_no_upd", 32'(score_upd), 32'd0);
      end else begin
        check("lat_ready_back", 32'(clr_ready), 32'd1);
        check("lat_upd", 32'(score_upd), 32'd1);
      end
    end

    // Asynchronous reset in the middle of ADD2
    @(negedge clk);
    wait_ready();
    clr_valid = 1'b1;
    clr_lines = 3'd2;
    @(posedge clk);
    model_accept(2);
    @(negedge clk);
    clr_valid = 1'b0;
    idle_cycles(2);
    rst_n = 1'b0;
    #1;
    check("async_rst_digits", 32'({score4, score3, score2, score1}), 32'd0);
    check("async_rst_ready", 32'(clr_ready), 32'd1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(8);

    // Ripple carry: 0099 -> 0100, 0999 -> 1007
    for (int i = 0; i < 12; i++) send(4);
    send(2);
    send(1);
    for (int i = 0; i < 112; i++) send(4);
    send(2);
    send(4);

    // Saturation: 9995 + 8 saturates, and stays there on the next event
    for (int i = 0; i < 1123; i++) send(4);
    send(2);
    send(1);
    check("pre_sat_model", 32'(model_score), 32'd9995);
    send(4);
    send(4);
    send(0);
    idle_cycles(8);
    check("sat_held_digits", 32'({score4, score3, score2, score1}), 32'h9999);

    // Valid held high: one accept every six cycles
    do_new_game();
    clr_valid = 1'b1;
    clr_lines = 3'd1;
    accepts = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      if (clr_ready) begin
        accepts++;
        model_accept(1);
      end
      @(negedge clk);
    end
    clr_valid = 1'b0;
    check("busy_accepts", 32'(accepts), 32'd5);
    send(0);
    send(6);
    idle_cycles(8);

    // new_game during ADD1 with score 0042 aborts the add
    do_new_game();
    for (int i = 0; i < 5; i++) send(4);
    send(1);
    send(1);
    @(negedge clk);
    wait_ready();
    clr_valid = 1'b1;
    clr_lines = 3'd3;
    @(posedge clk);
    model_accept(3);
    @(negedge clk);
    clr_valid = 1'b0;
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    check("ng_digits", 32'({score4, score3, score2, score1}), 32'd0);
    check("ng_ready", 32'(clr_ready), 32'd1);
    @(negedge clk);
    new_game = 1'b0;
    idle_cycles(8);

    // new_game beats a same-cycle accept
    for (int i = 0; i < 3; i++) send(3);
    idle_cycles(7);
    @(negedge clk);
    wait_ready();
    new_game  = 1'b1;
    clr_valid = 1'b1;
    clr_lines = 3'd4;
    @(posedge clk);
    model_clear();
    #1;
    check("ng_drop_ready", 32'(clr_ready), 32'd1);
    @(negedge clk);
    new_game  = 1'b0;
    clr_valid = 1'b0;
    idle_cycles(8);
    check("ng_drop_digits", 32'({score4, score3, score2, score1}), 32'd0);

    // Randomized events with occasional new_game
    for (int i = 0; i < 400; i++) begin
      send(($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 7)));
      idle_cycles($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        idle_cycles($urandom_range(0, 6));
        do_new_game();
      end
    end

    begin
      int waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
